// File: rtl/i3c_hdr_mode_ctrl.sv
// i3c_hdr_mode_ctrl: system-clock sequencer for I3C HDR mode.
// It synchronizes the exit/restart flags coming from the exit detector.
// It owns in_HDR_mode and HDR_restart_ack, and it selects which engine drives the bus.
// Unsupported HDR modes are entered as "ignore" and held until exit.
// Optional feature macro: HDR_TIMEOUT_EN adds an HDR watchdog driven by to_limit.
module i3c_hdr_mode_ctrl #(
  parameter logic [2:0] ENA_HDR     = 3'b000,
  parameter int         SYNC_STAGES = 2,
  parameter int         ACK_MIN     = 2,
  parameter int         TO_WIDTH    = 16
) (
  input  logic                clk_sys,
  input  logic                RST,
  input  logic                enthdr_pulse,
  input  logic [2:0]          enthdr_mode,
  input  logic                hdr_exit_async,
  input  logic                hdr_restart_async,
  input  logic [TO_WIDTH-1:0] to_limit,
  output logic                in_HDR_mode,
  output logic                HDR_restart_ack,
  output logic [2:0]          hdr_sel,
  output logic                hdr_ignore,
  output logic                hdr_exit_evt,
  output logic                hdr_restart_evt,
  output logic                hdr_timeout
);

  localparam logic [1:0] ST_SDR   = 2'd0;
  localparam logic [1:0] ST_HDR   = 2'd1;
  localparam logic [1:0] ST_ACK   = 2'd2;
  localparam logic [1:0] ST_EXITW = 2'd3;
  localparam int         ACK_W    = $clog2(ACK_MIN + 1);

  logic [SYNC_STAGES-1:0] r_exSync;
  logic [SYNC_STAGES-1:0] r_rsSync;
  logic                   r_exDly;
  logic                   r_rsDly;
  logic [1:0]             r_state;
  logic [ACK_W-1:0]       r_ackCnt;
  logic                   r_inHdr;
  logic                   r_ack;
  logic [2:0]             r_sel;
  logic                   r_ignore;
  logic                   r_exitEvt;
  logic                   r_restartEvt;
  logic                   r_timeout;
  logic                   w_exS;
  logic                   w_rsS;
  logic                   w_exR;
  logic                   w_rsR;
  logic                   w_modeOk;
  logic [3:0]             w_enaExt;
  logic                   w_toHit;

  assign w_exS    = r_exSync[SYNC_STAGES-1];
  assign w_rsS    = r_rsSync[SYNC_STAGES-1];
  assign w_exR    = w_exS & ~r_exDly;
  assign w_rsR    = w_rsS & ~r_rsDly;
  // Mode 3 is padded out as unsupported so the lookup stays in range.
  assign w_enaExt = {1'b0, ENA_HDR};
  assign w_modeOk = (enthdr_mode <= 3'd2) && w_enaExt[enthdr_mode[1:0]];

`ifdef HDR_TIMEOUT_EN
  logic [TO_WIDTH-1:0] r_toCnt;

  assign w_toHit = ((r_state == ST_HDR) || (r_state == ST_ACK)) &&
                   (to_limit != '0) && (r_toCnt == to_limit);

  // Watchdog counts while HDR owns the bus, restarts on any detector event, saturates at max.
  always_ff @(posedge clk_sys or posedge RST) begin
    if (RST) begin
      r_toCnt <= '0;
    end else if ((r_state == ST_SDR) || (r_state == ST_EXITW) || w_exR || w_rsR) begin
      r_toCnt <= '0;
    end else if (r_toCnt != '1) begin
      r_toCnt <= r_toCnt + 1'b1;
    end
  end
`else
  logic w_unused;

  assign w_toHit  = 1'b0;
  assign w_unused = ^to_limit;
`endif

  // CDC synchronizers for the detector flags, plus one extra flop each for rising-edge detection.
  always_ff @(posedge clk_sys or posedge RST) begin
    if (RST) begin
      r_exSync <= '0;
      r_rsSync <= '0;
      r_exDly  <= 1'b0;
      r_rsDly  <= 1'b0;
    end else begin
      r_exSync <= {r_exSync[SYNC_STAGES-2:0], hdr_exit_async};
      r_rsSync <= {r_rsSync[SYNC_STAGES-2:0], hdr_restart_async};
      r_exDly  <= w_exS;
      r_rsDly  <= w_rsS;
    end
  end

  // Mode sequencer: exit beats the watchdog, and the watchdog beats restart handling.
  always_ff @(posedge clk_sys or posedge RST) begin
    if (RST) begin
      r_state      <= ST_SDR;
      r_ackCnt     <= '0;
      r_inHdr      <= 1'b0;
      r_ack        <= 1'b0;
      r_sel        <= 3'b000;
      r_ignore     <= 1'b0;
      r_exitEvt    <= 1'b0;
      r_restartEvt <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_exitEvt    <= 1'b0;
      r_restartEvt <= 1'b0;
      r_timeout    <= 1'b0;
      case (r_state)
        ST_SDR: begin
          if (w_exR) begin
            r_exitEvt <= 1'b1;
          end else if (enthdr_pulse) begin
            r_state  <= ST_HDR;
            r_inHdr  <= 1'b1;
            r_sel    <= w_modeOk ? 3'(3'b001 << enthdr_mode[1:0]) : 3'b000;
            r_ignore <= ~w_modeOk;
          end
        end
        ST_HDR, ST_ACK: begin
          if (w_exR) begin
            r_state   <= ST_EXITW;
            r_inHdr   <= 1'b0;
            r_ack     <= 1'b0;
            r_sel     <= 3'b000;
            r_ignore  <= 1'b0;
            r_exitEvt <= 1'b1;
          end else if (w_toHit) begin
            r_state   <= ST_SDR;
            r_inHdr   <= 1'b0;
            r_ack     <= 1'b0;
            r_sel     <= 3'b000;
            r_ignore  <= 1'b0;
            r_timeout <= 1'b1;
          end else if (r_state == ST_HDR) begin
            if (w_rsR && (ENA_HDR != 3'b000)) begin
              r_state      <= ST_ACK;
              r_ack        <= 1'b1;
              r_restartEvt <= 1'b1;
              r_ackCnt     <= ACK_W'(1);
            end
          end else if ((r_ackCnt >= ACK_W'(ACK_MIN)) && !w_rsS) begin
            r_state <= ST_HDR;
            r_ack   <= 1'b0;
          end else if (r_ackCnt < ACK_W'(ACK_MIN)) begin
            r_ackCnt <= r_ackCnt + 1'b1;
          end
        end
        default: begin
          if (!w_exS) begin
            r_state <= ST_SDR;
          end
        end
      endcase
    end
  end

  assign in_HDR_mode     = r_inHdr;
  assign HDR_restart_ack = r_ack;
  assign hdr_sel         = r_sel;
  assign hdr_ignore      = r_ignore;
  assign hdr_exit_evt    = r_exitEvt;
  assign hdr_restart_evt = r_restartEvt;
  assign hdr_timeout     = r_timeout;

endmodule

// File: tb/tb_i3c_hdr_mode_ctrl.sv
// Testbench for i3c_hdr_mode_ctrl, configured with DDR support only (ENA_HDR=001).
// Stimulus pushes the expected output snapshots into a queue.
// A monitor pops one snapshot for every change in the DUT outputs and compares it.
// The watchdog sequence is built only when HDR_TIMEOUT_EN is defined.
module tb_i3c_hdr_mode_ctrl;

  logic        clk_sys = 1'b0;
  logic        RST = 1'b1;
  logic        enthdr_pulse = 1'b0;
  logic [2:0]  enthdr_mode = 3'd0;
  logic        hdr_exit_async = 1'b0;
  logic        hdr_restart_async = 1'b0;
  logic [15:0] to_limit = 16'd0;
  logic        in_HDR_mode;
  logic        HDR_restart_ack;
  logic [2:0]  hdr_sel;
  logic        hdr_ignore;
  logic        hdr_exit_evt;
  logic        hdr_restart_evt;
  logic        hdr_timeout;
  logic [8:0]  outVec;
  logic [8:0]  expQ[$];
  int          testsRun = 0;
  int          failCount = 0;

  i3c_hdr_mode_ctrl #(
    .ENA_HDR(3'b001), .SYNC_STAGES(2), .ACK_MIN(2), .TO_WIDTH(16)
  ) dut (
    .clk_sys(clk_sys), .RST(RST), .enthdr_pulse(enthdr_pulse), .enthdr_mode(enthdr_mode),
    .hdr_exit_async(hdr_exit_async), .hdr_restart_async(hdr_restart_async), .to_limit(to_limit),
    .in_HDR_mode(in_HDR_mode), .HDR_restart_ack(HDR_restart_ack), .hdr_sel(hdr_sel),
    .hdr_ignore(hdr_ignore), .hdr_exit_evt(hdr_exit_evt), .hdr_restart_evt(hdr_restart_evt),
    .hdr_timeout(hdr_timeout)
  );

  assign outVec = {in_HDR_mode, HDR_restart_ack, hdr_sel, hdr_ignore,
                   hdr_exit_evt, hdr_restart_evt, hdr_timeout};

  always #5 clk_sys = ~clk_sys;

  function automatic logic [8:0] mk(input logic ih, input logic ak, input logic [2:0] sl,
                                    input logic ig, input logic ex, input logic rs,
                                    input logic to);
    return {ih, ak, sl, ig, ex, rs, to};
  endfunction

  task automatic checkOutput(input string name, input logic [8:0] actual,
                             input logic [8:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  // Issues one ENTHDRn pulse; the DUT samples it on the first posedge.
  task automatic applyStimulus(input logic [2:0] mode);
    @(posedge clk_sys); #1;
    enthdr_pulse = 1'b1;
    enthdr_mode  = mode;
    @(posedge clk_sys); #1;
    enthdr_pulse = 1'b0;
  endtask

  // Raises exit, optionally together with restart, and checks the SYNC_STAGES+1 latency.
  task automatic exitHdr(input logic withRestart);
    expQ.push_back(mk(0, 0, 3'b000, 0, 1, 0, 0));
    expQ.push_back(mk(0, 0, 3'b000, 0, 0, 0, 0));
    @(posedge clk_sys); #1;
    hdr_exit_async    = 1'b1;
    hdr_restart_async = withRestart;
    repeat (2) @(posedge clk_sys);
    @(negedge clk_sys);
    checkOutput("exitLatencyHold", {8'd0, in_HDR_mode}, 9'd1);
    @(posedge clk_sys);
    @(negedge clk_sys);
    checkOutput("exitLatencyDrop", {8'd0, in_HDR_mode}, 9'd0);
    @(posedge clk_sys); #1;
    hdr_exit_async    = 1'b0;
    hdr_restart_async = 1'b0;
    repeat (5) @(posedge clk_sys);
  endtask

  // Pops one expected snapshot for every change seen on the DUT outputs.
  initial begin
    logic [8:0] prev;
    logic [8:0] cur;
    prev = '0;
    forever begin
      @(negedge clk_sys);
      cur = outVec;
      if (cur !== prev) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedChange", cur, prev);
        end else begin
          checkOutput("scoreboard", cur, expQ.pop_front());
        end
        prev = cur;
      end
    end
  end

  // Hard bound on the run, in case a wait never completes.
  initial begin
    #2000000;
    $display("[TB] FAIL globalTimeout: run did not finish, %0d tests run, %0d failed",
             testsRun, failCount);
    $fatal(1, "[TB] time limit reached");
  end

  // Directed sequences.
  initial begin
    int ackCycles;
    int n;
    repeat (3) @(posedge clk_sys);
    #1;
    checkOutput("resetState", outVec, 9'd0);
    RST = 1'b0;
    repeat (2) @(posedge clk_sys);

    // DDR entry, then a normal exit.
    expQ.push_back(mk(1, 0, 3'b001, 0, 0, 0, 0));
    applyStimulus(3'd0);
    exitHdr(1'b0);

    // Unsupported modes enter ignore mode.
    for (int m = 1; m <= 3; m++) begin
      expQ.push_back(mk(1, 0, 3'b000, 1, 0, 0, 0));
      applyStimulus(3'(m));
      exitHdr(1'b0);
    end

    // A long restart, and ENTHDR being ignored while in HDR.
    expQ.push_back(mk(1, 0, 3'b001, 0, 0, 0, 0));
    applyStimulus(3'd0);
    applyStimulus(3'd1);
    expQ.push_back(mk(1, 1, 3'b001, 0, 0, 1, 0));
    expQ.push_back(mk(1, 1, 3'b001, 0, 0, 0, 0));
    expQ.push_back(mk(1, 0, 3'b001, 0, 0, 0, 0));
    @(posedge clk_sys); #1;
    hdr_restart_async = 1'b1;
    repeat (10) @(posedge clk_sys);
    #1;
    hdr_restart_async = 1'b0;
    repeat (2) @(posedge clk_sys);
    @(negedge clk_sys);
    checkOutput("ackHoldAfterRestart", {8'd0, HDR_restart_ack}, 9'd1);
    @(posedge clk_sys);
    @(negedge clk_sys);
    checkOutput("ackDropAfterRestart", {8'd0, HDR_restart_ack}, 9'd0);

    // A one-cycle restart must still hold the ack for ACK_MIN cycles.
    expQ.push_back(mk(1, 1, 3'b001, 0, 0, 1, 0));
    expQ.push_back(mk(1, 1, 3'b001, 0, 0, 0, 0));
    expQ.push_back(mk(1, 0, 3'b001, 0, 0, 0, 0));
    @(posedge clk_sys); #1;
    hdr_restart_async = 1'b1;
    @(posedge clk_sys); #1;
    hdr_restart_async = 1'b0;
    ackCycles = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_sys);
      if (HDR_restart_ack) ackCycles++;
    end
    checkOutput("ackMinWidth", 9'(ackCycles), 9'd2);
    exitHdr(1'b0);

    // Exit and restart together: exit wins.
    expQ.push_back(mk(1, 0, 3'b001, 0, 0, 0, 0));
    applyStimulus(3'd0);
    exitHdr(1'b1);

    // An exit seen while already in SDR still pulses the exit event.
    expQ.push_back(mk(0, 0, 3'b000, 0, 1, 0, 0));
    expQ.push_back(mk(0, 0, 3'b000, 0, 0, 0, 0));
    @(posedge clk_sys); #1;
    hdr_exit_async = 1'b1;
    repeat (4) @(posedge clk_sys);
    #1;
    hdr_exit_async = 1'b0;
    repeat (4) @(posedge clk_sys);

    // Reset while in ACK, then re-entry.
    expQ.push_back(mk(1, 0, 3'b001, 0, 0, 0, 0));
    applyStimulus(3'd0);
    expQ.push_back(mk(1, 1, 3'b001, 0, 0, 1, 0));
    expQ.push_back(mk(1, 1, 3'b001, 0, 0, 0, 0));
    expQ.push_back(mk(0, 0, 3'b000, 0, 0, 0, 0));
    @(posedge clk_sys); #1;
    hdr_restart_async = 1'b1;
    repeat (5) @(posedge clk_sys);
    #2;
    RST = 1'b1;
    #1;
    checkOutput("asyncResetHdr", {8'd0, in_HDR_mode}, 9'd0);
    checkOutput("asyncResetAck", {8'd0, HDR_restart_ack}, 9'd0);
    hdr_restart_async = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;
    RST = 1'b0;
    expQ.push_back(mk(1, 0, 3'b001, 0, 0, 0, 0));
    applyStimulus(3'd0);
    exitHdr(1'b0);

`ifdef HDR_TIMEOUT_EN
    // Watchdog expiry with to_limit=100.
    to_limit = 16'd100;
    expQ.push_back(mk(1, 0, 3'b001, 0, 0, 0, 0));
    expQ.push_back(mk(0, 0, 3'b000, 0, 0, 0, 1));
    expQ.push_back(mk(0, 0, 3'b000, 0, 0, 0, 0));
    applyStimulus(3'd0);
    n = 0;
    while (n < 300) begin
      @(posedge clk_sys);
      n++;
      @(negedge clk_sys);
      if (hdr_timeout) break;
    end
    checkOutput("timeoutCycle", 9'(n), 9'd101);
    to_limit = 16'd0;
    repeat (3) @(posedge clk_sys);
`else
    n = 0;
`endif

    repeat (10) @(posedge clk_sys);
    checkOutput("queueDrained", 9'(expQ.size()), 9'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
